// File: rtl/mmio_requester_if.sv
// MMIO requester bundle: command port, request pulses,
// read responses and completion reporting.
interface mmio_requester_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64,
  parameter int TID_W  = 9
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              req_wr_valid;
  logic              req_rd_valid;
  logic [ADDR_W-1:0] req_addr;
  logic [TID_W-1:0]  req_tid;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic [TID_W-1:0]  rsp_tid;
  logic [DATA_W-1:0] rsp_data;
  logic              done_valid;
  logic [DATA_W-1:0] done_data;
  logic              done_error;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  rsp_valid, rsp_tid, rsp_data,
    output cmd_ready,
    output req_wr_valid, req_rd_valid,
    output req_addr, req_tid, req_data,
    output done_valid, done_data, done_error
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output rsp_valid, rsp_tid, rsp_data,
    input  cmd_ready,
    input  req_wr_valid, req_rd_valid,
    input  req_addr, req_tid, req_data,
    input  done_valid, done_data, done_error
  );
endinterface

// File: rtl/mmio_requester.sv
// MMIO initiator: issues one write/read request per command,
// matches read responses by TID, times out lost reads.
module mmio_requester #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 64,
  parameter int TID_W   = 9,
  parameter int TIMEOUT = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  mmio_requester_if.master   bus,
  output logic               busy,
  output logic [7:0]         stray_cnt
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    DONE
  } state_t;

  state_t state, state_nx;

  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [TID_W-1:0]  tid_q;
  logic [TID_W-1:0]  tid_cnt;
  logic [CW-1:0]     to_cnt;
  logic [DATA_W-1:0] dd_q;
  logic              de_q;

  logic accept;
  logic hit;
  logic expire;

  assign accept = bus.cmd_valid && (state == IDLE);
  assign hit    = (state == WAIT_RSP) && bus.rsp_valid
                  && (bus.rsp_tid == tid_q);
  assign expire = (state == WAIT_RSP) && !hit
                  && (to_cnt == TO_LAST);

  assign bus.cmd_ready    = (state == IDLE);
  assign bus.req_wr_valid = (state == ISSUE) && wr_q;
  assign bus.req_rd_valid = (state == ISSUE) && !wr_q;
  assign bus.req_addr     = addr_q;
  assign bus.req_data     = data_q;
  assign bus.req_tid      = tid_q;
  assign bus.done_valid   = (state == DONE);
  assign bus.done_data    = dd_q;
  assign bus.done_error   = de_q;
  assign busy             = (state != IDLE);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (accept) state_nx = ISSUE;
      ISSUE:    state_nx = wr_q ? DONE : WAIT_RSP;
      WAIT_RSP: if (hit || expire) state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // command capture and TID allocation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      tid_q   <= '0;
      tid_cnt <= '0;
    end else begin
      if (accept) begin
        wr_q   <= bus.cmd_write;
        addr_q <= bus.cmd_addr;
        data_q <= bus.cmd_wdata;
        if (!bus.cmd_write) tid_q <= tid_cnt;
      end
      if (state == ISSUE && !wr_q)
        tid_cnt <= tid_cnt + 1'b1;
    end
  end

  // response wait timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state == ISSUE) begin
      to_cnt <= '0;
    end else if (state == WAIT_RSP && !hit && !expire) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // completion result, held until the next completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dd_q <= '0;
      de_q <= 1'b0;
    end else if (state == ISSUE && wr_q) begin
      dd_q <= '0;
      de_q <= 1'b0;
    end else if (hit) begin
      dd_q <= bus.rsp_data;
      de_q <= 1'b0;
    end else if (expire) begin
      dd_q <= '0;
      de_q <= 1'b1;
    end
  end

  // saturating count of responses nobody is waiting for
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stray_cnt <= '0;
    else if (bus.rsp_valid && !hit && stray_cnt != 8'hFF)
      stray_cnt <= stray_cnt + 8'd1;
  end

endmodule

// File: doc/mmio_requester.md
Name: mmio_requester

Overview:
MMIO initiator for the simplified CCI-P MMIO path. It is the host-side end that drives MMIO write and read requests into an AFU and collects the read responses. It accepts one command at a time from a local valid/ready command port and issues a single-cycle request pulse. For reads, it tracks the transaction ID (TID), waits for the matching response with a timeout, and reports completion on a one-cycle done pulse. Its uses are on-chip self-test of AFU register maps and bench-free loopback of MMIO responders.

Parameters:
ADDR_W, 16, MMIO address width (word address, same encoding as the AFU decode, e.g. 16'h0020)
DATA_W, 64, MMIO data width
TID_W, 9, transaction ID width
TIMEOUT, 256, read-response wait limit in cycles (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1=MMIO write, 0=MMIO read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
req_wr_valid  out  1  MMIO write request pulse (maps to rx.c0.mmioWrValid)
req_rd_valid  out  1  MMIO read request pulse (maps to rx.c0.mmioRdValid)
req_addr  out  ADDR_W  request address (hdr.address)
req_tid  out  TID_W  request TID (hdr.tid)
req_data  out  DATA_W  write data (rx.c0.data[63:0])
rsp_valid  in  1  read response valid (tx.c2.mmioRdValid)
rsp_tid  in  TID_W  response TID (tx.c2.hdr.tid)
rsp_data  in  DATA_W  response data (tx.c2.data)
done_valid  out  1  one-cycle completion pulse
done_data  out  DATA_W  read data; 0 for writes and timeouts
done_error  out  1  1 = read timed out
busy  out  1  state != IDLE
stray_cnt  out  8  saturating count of unmatched responses

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0 except cmd_ready=1; internal TID counter=0; timeout counter=0; stray_cnt=0. Reset mid-transaction abandons the transaction and emits no done pulse.
- States: IDLE, ISSUE, WAIT_RSP, DONE.
- IDLE: cmd_ready=1, the only state where it is 1. On accept at cycle T:
  - latch write, addr, wdata;
  - req_tid <= TID counter for reads; TID is unchanged for writes;
  - go to ISSUE.
- ISSUE (cycle T+1):
  - exactly one of req_wr_valid/req_rd_valid is 1 for exactly this cycle;
  - req_addr, req_data and req_tid are stable from T+1 until the next accept;
  - write: go to DONE;
  - read: TID counter += 1 (wraps mod 2^TID_W), clear timeout counter, go to WAIT_RSP.
- WAIT_RSP (from T+2):
  - rsp_valid && rsp_tid==req_tid: capture rsp_data, go to DONE with error=0;
  - rsp_valid with a mismatched TID: ignored, stray_cnt += 1 (saturates at 255);
  - TIMEOUT consecutive WAIT_RSP cycles without a match: go to DONE with error=1, data=0;
  - a match arriving in the same cycle the limit is reached wins (error=0).
- DONE: done_valid=1 for one cycle with done_data/done_error, then IDLE. No backpressure on done.
- Latency:
  - write: done at T+2, cmd_ready high again at T+3;
  - read with a responder returning at cycle R (R>=T+2): done at R+1;
  - with a 1-cycle registered responder, read done is at T+3.
- rsp_valid outside WAIT_RSP (IDLE, ISSUE, DONE) counts as stray and is otherwise ignored.
- cmd_valid while not in IDLE: not accepted; the command must be held by the source.
- done_data and done_error hold their values until the next DONE; done_valid is the qualifier.

Test Plan:
- Write: cmd write addr=16'h0020 wdata=64'hDEADBEEF_CAFEF00D at T -> req_wr_valid=1 only at T+1 with req_addr=16'h0020, req_data=DEADBEEF_CAFEF00D; done_valid at T+2, done_error=0, done_data=0; cmd_ready=1 at T+3.
- Write then read loopback with an AFU responder model: write 64'h1234 to 16'h0020, then read 16'h0020 -> req_rd_valid with req_tid=0, response tid=0, done_data=64'h1234. A following read of 16'h0000 gets req_tid=1 and done_data whose top nibble is 4'b0001.
- Timeout: read issued, no response, TIMEOUT=256 -> done_valid 256 cycles after WAIT_RSP entry, done_error=1, done_data=0; next read uses the incremented TID.
- TID filtering: during WAIT_RSP for tid=5, inject rsp tid=4 data=AA then tid=5 data=BB -> stray_cnt=1, done_data=BB. Inject 300 stray responses -> stray_cnt saturates at 255.
- TID wrap: 512 reads with TID_W=9 -> TIDs run 0..511, then 0 on the 513th.
- Reset mid-read: drop rst_n during WAIT_RSP -> outputs 0 immediately, no done pulse, cmd_ready=1 after release, next read uses TID 0.
